sd_sector_buffer: RTL and testbench
===================================

Name: sd_sector_buffer

Overview:
Sector-level front end placed directly upstream of the SD card controller. It owns a 512-byte sector RAM and turns single-cycle host commands (read LBA / write LBA) into the controller's enable/strobe handshakes. On a read it collects the controller's 512 byte strobes into the RAM; on a write it feeds the RAM contents byte by byte. The host accesses the RAM through a simple byte port whenever the block is not busy.

Parameters:
ADDR_MODE, 0, 0 = byte-addressed card (o_sd_address = lba<<9); 1 = block-addressed card (o_sd_address = lba)
SECTOR_BYTES, 512, bytes per transfer; also sets the RAM depth
TIMEOUT_CYCLES, 50_000_000, maximum i_clk cycles without progress before the block flags an error

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_cmd_read  in  1  one-cycle request: read sector i_lba into the RAM
i_cmd_write  in  1  one-cycle request: write the RAM to sector i_lba
i_lba  in  32  sector number, sampled when a command is accepted
o_busy  out  1  high from command acceptance until o_done or o_error
o_done  out  1  one-cycle pulse when a transfer completes
o_error  out  1  sticky timeout flag; cleared when the next command is accepted
i_buf_addr  in  9  host RAM byte address
i_buf_we  in  1  host RAM write strobe; ignored while o_busy
i_buf_wdata  in  8  host RAM write data
o_buf_rdata  out  8  host RAM read data, 1-cycle latency, valid in every state
i_sd_ready  in  1  controller is idle
o_sd_read_en  out  1  controller read enable
o_sd_write_en  out  1  controller write enable
o_sd_address  out  32  controller address
i_sd_rdata  in  8  controller read byte
i_sd_byte_avai  in  1  controller byte strobe
i_sd_ready_write  in  1  controller write-byte handshake
o_sd_wdata  out  8  byte presented to the controller

Behaviour:
- Reset values: state S_IDLE; o_busy, o_done, o_error, o_sd_read_en and o_sd_write_en all 0; o_sd_address 0; byte count 0; edge-detect registers 0. RAM contents are not reset. A reset mid-transfer aborts immediately with no o_done.
- Edge detection: i_sd_byte_avai and i_sd_ready_write are registered once. Only rising edges count as events.
- S_IDLE:
  - i_cmd_read has priority over i_cmd_write when both are asserted.
  - On accept: latch the address, clear o_error, set o_busy, clear the byte count and timer, go to S_WAIT_CARD.
  - Commands arriving while o_busy is high are ignored.
- S_WAIT_CARD: wait for i_sd_ready=1, then assert the matching enable (o_sd_read_en or o_sd_write_en) for exactly 1 cycle and go to S_WAIT_ACK.
- S_WAIT_ACK: wait for i_sd_ready=0, then go to S_RD_DATA or S_WR_DATA.
- S_RD_DATA:
  - Each byte_avai rise writes i_sd_rdata to RAM[count] and increments count.
  - Rises after count reaches SECTOR_BYTES are ignored.
  - When count = SECTOR_BYTES and i_sd_ready=1, go to S_DONE.
- S_WR_DATA:
  - o_sd_wdata = RAM[count] via the sync read port; this is valid one cycle after count changes.
  - The first ready_write rise of each transaction is the command-phase marker and is ignored.
  - Every later rise means the current byte has been consumed: increment count.
  - When count = SECTOR_BYTES and i_sd_ready=1, go to S_DONE.
  - While count = SECTOR_BYTES, o_sd_wdata holds 8'hFF.
- S_DONE: pulse o_done for 1 cycle, drop o_busy, go to S_IDLE.
- Timeout:
  - The timer counts in S_WAIT_CARD, S_WAIT_ACK, S_RD_DATA and S_WR_DATA.
  - It clears on each state entry and on each counted byte event.
  - At TIMEOUT_CYCLES: set o_error, drop o_busy, go to S_IDLE with no o_done.
- Count width is 10 bits so that 512 is representable; the RAM address is count[8:0].
- Address: ADDR_MODE=0 gives {lba[22:0], 9'b0}, so lba bits 31:23 are truncated; ADDR_MODE=1 gives lba unchanged.
- Host RAM port: 1-cycle read latency in all states. Host writes are blocked while o_busy; the block's own port has priority.

Decomposition:
- Package sd_pkg holds:
  - the state enum (S_IDLE, S_WAIT_CARD, S_WAIT_ACK, S_RD_DATA, S_WR_DATA, S_DONE);
  - the constants SECTOR_BYTES=512 and SD_DATA_TOKEN=8'hFE;
  - the default TIMEOUT_CYCLES.
- Sub-module sd_sector_ram: a true-dual-port 512x8 RAM with synchronous reads, one port for the host and one for the FSM. It must infer BRAM.

Test Plan:
1. Read: i_cmd_read with lba=3, ADDR_MODE=0, and a controller BFM returning bytes i&8'hFF. Required: o_sd_address=32'h600; o_sd_read_en high exactly 1 cycle; o_done after the 512th strobe; host readback gives RAM[0..511]=0..255,0..255.
2. Write: host fills RAM[i]=~i, then i_cmd_write with lba=7, ADDR_MODE=1. Required: BFM sees address 7, ignores the first ready_write rise, and captures 512 bytes equal to ~i in order; o_done asserted once.
3. Simultaneous: i_cmd_read and i_cmd_write in the same cycle. Required: only o_sd_read_en fires. A second i_cmd_write during busy is ignored and no second transaction occurs.
4. Timeout: TIMEOUT_CYCLES=1000; BFM stops after 100 strobes. Required: o_error=1 and o_busy=0 about 1000 cycles after the last strobe, with no o_done. The next command clears o_error.
5. Reset mid-read: assert i_reset after 50 strobes. Required: next cycle state is S_IDLE and all outputs hold their reset values. A fresh read then completes normally.
6. Host write while busy: i_buf_we to address 0 with 8'hAA during a read. Required: RAM[0] equals the card byte, not 8'hAA.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_pkg
//  Description : Shared types and constants for the SD sector buffer:
//                FSM state encoding, sector size, data token and the
//                default no-progress timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_CARD = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_RD_DATA   = 3'd3,
        S_WR_DATA   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int          SECTOR_BYTES           = 512;
    localparam logic [7:0]  SD_DATA_TOKEN          = 8'hFE;
    localparam int          TIMEOUT_CYCLES_DEFAULT = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/sd_sector_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sector_ram
//  Description : True-dual-port sector RAM with synchronous, read-first
//                reads on both ports. Port A serves the host, port B the
//                transfer FSM. When both ports write the same address in
//                one cycle, port B wins.
//  Ports       : i_clk                         - clock
//                i_a_addr/i_a_we/i_a_wdata     - host port address/strobe/data
//                o_a_rdata                     - host read data (1-cycle latency)
//                i_b_addr/i_b_we/i_b_wdata     - FSM port address/strobe/data
//                o_b_rdata                     - FSM read data (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_ram
    import sd_pkg::*;
#(
    parameter int DEPTH  = SECTOR_BYTES,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic              i_a_we,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic              i_b_we,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        // Later assignment wins, giving the FSM port priority on a clash.
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
        o_a_rdata <= r_mem[i_a_addr];
        o_b_rdata <= r_mem[i_b_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sd_sector_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sd_sector_buffer
//  Description : Sector front end for an SD card controller. Turns one-cycle
//                read/write LBA commands into controller enable/strobe
//                handshakes, moving 512 bytes between the card and an
//                internal sector RAM that the host accesses while idle.
//  Ports       : i_clk, i_reset              - clock, sync active-high reset
//                i_cmd_read/i_cmd_write/i_lba - host command interface
//                o_busy/o_done/o_error        - host status
//                i_buf_addr/i_buf_we/i_buf_wdata/o_buf_rdata - host RAM port
//                i_sd_* / o_sd_*              - SD controller handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_buffer #(
    parameter int ADDR_MODE      = 0,
    parameter int SECTOR_BYTES   = sd_pkg::SECTOR_BYTES,
    parameter int TIMEOUT_CYCLES = sd_pkg::TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_read,
    input  logic        i_cmd_write,
    input  logic [31:0] i_lba,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    input  logic [8:0]  i_buf_addr,
    input  logic        i_buf_we,
    input  logic [7:0]  i_buf_wdata,
    output logic [7:0]  o_buf_rdata,
    input  logic        i_sd_ready,
    output logic        o_sd_read_en,
    output logic        o_sd_write_en,
    output logic [31:0] o_sd_address,
    input  logic [7:0]  i_sd_rdata,
    input  logic        i_sd_byte_avai,
    input  logic        i_sd_ready_write,
    output logic [7:0]  o_sd_wdata
);
    import sd_pkg::*;

    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       CNT_FULL  = 10'(SECTOR_BYTES);

    state_t            r_state;
    logic [9:0]        r_count;
    logic [TMR_W-1:0]  r_timer;
    logic              r_avai_d;
    logic              r_rdyw_d;
    logic              r_is_write;
    logic              r_marker_seen;

    logic              w_avai_rise;
    logic              w_rdyw_rise;
    logic              w_full;
    logic              w_timeout;
    logic              w_ram_we;
    logic              w_wr_consume;
    logic              w_host_we;
    logic [31:0]       w_card_address;
    logic [7:0]        w_ram_rdata;

    assign w_avai_rise  = i_sd_byte_avai   & ~r_avai_d;
    assign w_rdyw_rise  = i_sd_ready_write & ~r_rdyw_d;
    assign w_full       = (r_count == CNT_FULL);
    assign w_timeout    = (r_timer == TMR_LIMIT);
    assign w_ram_we     = (r_state == S_RD_DATA) && w_avai_rise && !w_full;
    // The first ready_write rise marks the command phase, not a byte.
    assign w_wr_consume = (r_state == S_WR_DATA) && w_rdyw_rise && r_marker_seen && !w_full;
    assign w_host_we    = i_buf_we && !o_busy;

    // Byte-addressed cards take lba*512; the upper lba bits fall off the top.
    assign w_card_address = (ADDR_MODE != 0) ? i_lba : {i_lba[22:0], 9'd0};

    // Past the last byte the controller sees idle-bus 0xFF, not a stale byte.
    assign o_sd_wdata = w_full ? 8'hFF : w_ram_rdata;

    sd_sector_ram #(
        .DEPTH  (512),
        .ADDR_W (9),
        .DATA_W (8)
    ) u_ram (
        .i_clk     (i_clk),
        .i_a_addr  (i_buf_addr),
        .i_a_we    (w_host_we),
        .i_a_wdata (i_buf_wdata),
        .o_a_rdata (o_buf_rdata),
        .i_b_addr  (r_count[8:0]),
        .i_b_we    (w_ram_we),
        .i_b_wdata (i_sd_rdata),
        .o_b_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_sd_read_en  <= 1'b0;
            o_sd_write_en <= 1'b0;
            o_sd_address  <= 32'd0;
            r_count       <= 10'd0;
            r_timer       <= '0;
            r_avai_d      <= 1'b0;
            r_rdyw_d      <= 1'b0;
            r_is_write    <= 1'b0;
            r_marker_seen <= 1'b0;
        end else begin
            r_avai_d      <= i_sd_byte_avai;
            r_rdyw_d      <= i_sd_ready_write;
            o_done        <= 1'b0;
            o_sd_read_en  <= 1'b0;
            o_sd_write_en <= 1'b0;

            // The marker may arrive before the data phase is entered.
            if (o_busy && w_rdyw_rise) begin
                r_marker_seen <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_cmd_read || i_cmd_write) begin
                        r_is_write    <= !i_cmd_read;
                        o_sd_address  <= w_card_address;
                        o_error       <= 1'b0;
                        o_busy        <= 1'b1;
                        r_count       <= 10'd0;
                        r_timer       <= '0;
                        r_marker_seen <= 1'b0;
                        r_state       <= S_WAIT_CARD;
                    end
                end

                S_WAIT_CARD: begin
                    if (i_sd_ready) begin
                        o_sd_read_en  <= !r_is_write;
                        o_sd_write_en <= r_is_write;
                        r_timer       <= '0;
                        r_state       <= S_WAIT_ACK;
                    end else if (w_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WAIT_ACK: begin
                    if (!i_sd_ready) begin
                        r_timer <= '0;
                        r_state <= r_is_write ? S_WR_DATA : S_RD_DATA;
                    end else if (w_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_RD_DATA: begin
                    if (w_full && i_sd_ready) begin
                        r_state <= S_DONE;
                    end else if (w_ram_we) begin
                        r_count <= r_count + 10'd1;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_WR_DATA: begin
                    if (w_full && i_sd_ready) begin
                        r_state <= S_DONE;
                    end else if (w_wr_consume) begin
                        r_count <= r_count + 10'd1;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DONE: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_sector_buffer
//  Description : Scoreboard bench for sd_sector_buffer. Two instances run in
//                lock-step (byte- and block-addressed). A controller model
//                drives the card side; expected enables, outcomes, host
//                readback bytes and card write bytes are queued at stimulus
//                time and checked by independent monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sector_buffer;

    logic        clk = 1'b0;
    logic        reset, cmd_read, cmd_write, buf_we, sd_ready, sd_byte_avai, sd_ready_write;
    logic [31:0] lba;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_wdata, sd_rdata;

    logic        busy, done, error, rd_en, wr_en;
    logic [31:0] address;
    logic [7:0]  buf_rdata, sd_wdata;
    logic        b_busy, b_done, b_error, b_rd_en, b_wr_en;
    logic [31:0] b_address;
    logic [7:0]  b_buf_rdata, b_sd_wdata;

    always #5 clk = ~clk;

    sd_sector_buffer #(.ADDR_MODE(0), .TIMEOUT_CYCLES(1000)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_cmd_read(cmd_read), .i_cmd_write(cmd_write),
        .i_lba(lba), .o_busy(busy), .o_done(done), .o_error(error),
        .i_buf_addr(buf_addr), .i_buf_we(buf_we), .i_buf_wdata(buf_wdata), .o_buf_rdata(buf_rdata),
        .i_sd_ready(sd_ready), .o_sd_read_en(rd_en), .o_sd_write_en(wr_en), .o_sd_address(address),
        .i_sd_rdata(sd_rdata), .i_sd_byte_avai(sd_byte_avai), .i_sd_ready_write(sd_ready_write),
        .o_sd_wdata(sd_wdata));

    sd_sector_buffer #(.ADDR_MODE(1), .TIMEOUT_CYCLES(1000)) u_dut_blk (
        .i_clk(clk), .i_reset(reset), .i_cmd_read(cmd_read), .i_cmd_write(cmd_write),
        .i_lba(lba), .o_busy(b_busy), .o_done(b_done), .o_error(b_error),
        .i_buf_addr(buf_addr), .i_buf_we(buf_we), .i_buf_wdata(buf_wdata), .o_buf_rdata(b_buf_rdata),
        .i_sd_ready(sd_ready), .o_sd_read_en(b_rd_en), .o_sd_write_en(b_wr_en), .o_sd_address(b_address),
        .i_sd_rdata(sd_rdata), .i_sd_byte_avai(sd_byte_avai), .i_sd_ready_write(sd_ready_write),
        .o_sd_wdata(b_sd_wdata));

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_strobe_cyc = 0;
    logic [7:0]  model_mem  [512];
    logic [7:0]  card_bytes [512];
    logic [7:0]  rd_q  [$];
    logic [65:0] en_q  [$];
    bit          out_q [$];
    logic [7:0]  exp_w [$];
    logic [15:0] got_w [$];
    logic        rd_req = 1'b0;
    logic        rd_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_vld <= rd_req;

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=no-event expected=event", name);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitor: host readback, controller enables and transfer outcomes.
    initial begin
        logic        err_d;
        logic [65:0] e;
        bit          ok;
        err_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (rd_q.size() == 0) fail_now("readback_unexpected");
                else begin
                    e[7:0] = rd_q.pop_front();
                    chk("readback", {buf_rdata, b_buf_rdata}, {e[7:0], e[7:0]});
                end
            end
            if (rd_en || wr_en) begin
                if (en_q.size() == 0) fail_now("enable_unexpected");
                else begin
                    e = en_q.pop_front();
                    chk("enable", {wr_en, rd_en, address, b_address}, e);
                    chk("blk_enable", {b_wr_en, b_rd_en}, e[65:64]);
                end
            end
            if (done || (error && !err_d)) begin
                if (out_q.size() == 0) fail_now("outcome_unexpected");
                else begin
                    ok = out_q.pop_front();
                    chk("outcome", {done, error, busy}, ok ? 3'b100 : 3'b010);
                    chk("blk_outcome", {b_done, b_error, b_busy}, ok ? 3'b100 : 3'b010);
                end
            end
            err_d = error;
        end
    end

    // Checker for bytes the controller model captured during writes.
    initial begin
        logic [15:0] g;
        logic [7:0]  e;
        forever begin
            @(posedge clk);
            while (got_w.size() > 0) begin
                g = got_w.pop_front();
                if (exp_w.size() == 0) fail_now("wr_byte_unexpected");
                else begin
                    e = exp_w.pop_front();
                    chk("wr_byte", g, {e, e});
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] l, input bit ok);
        cmd_read  = rd;
        cmd_write = wr;
        lba       = l;
        en_q.push_back({(!rd && wr), rd, (l << 9), l});
        out_q.push_back(ok);
        tick();
        cmd_read  = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic wait_enable(output bit seen);
        int n = 0;
        sd_ready = 1'b1;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            tick();
            n++;
            seen = rd_en || wr_en;
        end
        if (!seen) fail_now("enable_wait");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) fail_now("idle_wait");
    endtask

    task automatic bfm_read(input int nbytes, input bit finish, input int poke);
        bit seen;
        wait_enable(seen);
        if (!seen) return;
        sd_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < nbytes; i++) begin
            sd_rdata     = card_bytes[i];
            sd_byte_avai = 1'b1;
            last_strobe_cyc = cyc;
            if (i == poke) begin
                buf_addr  = 9'd0;
                buf_wdata = 8'hAA;
                buf_we    = 1'b1;
            end
            tick();
            sd_byte_avai = 1'b0;
            buf_we       = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        if (finish) begin
            sd_ready = 1'b1;
            tick();
            wait_idle();
        end
    endtask

    task automatic bfm_write();
        bit seen;
        wait_enable(seen);
        if (!seen) return;
        sd_ready = 1'b0;
        tick();
        tick();
        sd_ready_write = 1'b1;
        tick();
        sd_ready_write = 1'b0;
        tick();
        for (int i = 0; i <= 512; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            got_w.push_back({sd_wdata, b_sd_wdata});
            if (i < 512) begin
                sd_ready_write = 1'b1;
                tick();
                sd_ready_write = 1'b0;
                tick();
            end
        end
        sd_ready = 1'b1;
        tick();
        wait_idle();
    endtask

    task automatic host_write(input int a, input logic [7:0] d);
        buf_addr  = 9'(a);
        buf_wdata = d;
        buf_we    = 1'b1;
        tick();
        buf_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic readback(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            buf_addr = 9'(a);
            rd_req   = 1'b1;
            rd_q.push_back(model_mem[a]);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic readback_random(input int n);
        int a;
        for (int k = 0; k < n; k++) begin
            a = $urandom_range(0, 511);
            buf_addr = 9'(a);
            rd_req   = 1'b1;
            rd_q.push_back(model_mem[a]);
            tick();
        end
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic random_card();
        for (int i = 0; i < 512; i++) card_bytes[i] = 8'($urandom);
    endtask

    task automatic expect_write_bytes();
        for (int i = 0; i < 512; i++) exp_w.push_back(model_mem[i]);
        exp_w.push_back(8'hFF);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {busy, done, error, rd_en, wr_en, address}, 37'd0);
        chk({name, "_blk"}, {b_busy, b_done, b_error, b_rd_en, b_wr_en, b_address}, 37'd0);
    endtask

    initial begin
        int lat;
        int n;
        reset = 1'b1; cmd_read = 1'b0; cmd_write = 1'b0; lba = 32'd0;
        buf_addr = 9'd0; buf_we = 1'b0; buf_wdata = 8'd0;
        sd_ready = 1'b1; sd_rdata = 8'd0; sd_byte_avai = 1'b0; sd_ready_write = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        chk_reset_outputs("reset_state");

        // Read lba 3 with incrementing card data; host write to addr 0 mid-read must be dropped.
        for (int i = 0; i < 512; i++) card_bytes[i] = 8'(i);
        issue(1'b1, 1'b0, 32'd3, 1'b1);
        bfm_read(512, 1'b1, 10);
        for (int i = 0; i < 512; i++) model_mem[i] = card_bytes[i];
        readback(0, 511);

        // Host fills ~i, then write lba 7.
        for (int i = 0; i < 512; i++) host_write(i, ~8'(i));
        expect_write_bytes();
        issue(1'b0, 1'b1, 32'd7, 1'b1);
        bfm_write();

        // Simultaneous read+write: read wins; a write during busy is ignored.
        random_card();
        sd_ready = 1'b0;
        issue(1'b1, 1'b1, $urandom, 1'b1);
        cmd_write = 1'b1;
        lba = $urandom;
        tick();
        cmd_write = 1'b0;
        bfm_read(512, 1'b1, -1);
        for (int i = 0; i < 512; i++) model_mem[i] = card_bytes[i];
        repeat (30) tick();
        readback_random(32);

        // Timeout after 100 strobes.
        random_card();
        issue(1'b1, 1'b0, $urandom, 1'b0);
        bfm_read(100, 1'b0, -1);
        n = 0;
        while (!error && n < 3000) begin
            tick();
            n++;
        end
        if (!error) fail_now("timeout_wait");
        else begin
            lat = cyc - last_strobe_cyc;
            checks++;
            if (lat < 990 || lat > 1010) begin
                failures++;
                $display("FAIL timeout_latency got=%0d expected=990..1010", lat);
            end
        end
        chk("busy_after_timeout", {busy, done}, 2'b00);
        for (int i = 0; i < 100; i++) model_mem[i] = card_bytes[i];
        sd_ready = 1'b1;
        tick();
        random_card();
        issue(1'b1, 1'b0, $urandom, 1'b1);
        chk("error_cleared", {error, busy}, 2'b01);
        bfm_read(512, 1'b1, -1);
        for (int i = 0; i < 512; i++) model_mem[i] = card_bytes[i];
        readback_random(32);

        // Reset after 50 strobes: outputs back to reset values, RAM keeps partial data.
        random_card();
        issue(1'b1, 1'b0, $urandom, 1'b1);
        bfm_read(50, 1'b0, -1);
        reset = 1'b1;
        tick();
        chk_reset_outputs("reset_mid_read");
        reset = 1'b0;
        void'(out_q.pop_back());
        sd_ready = 1'b1;
        for (int i = 0; i < 50; i++) model_mem[i] = card_bytes[i];
        tick();
        readback(0, 63);
        random_card();
        issue(1'b1, 1'b0, $urandom, 1'b1);
        bfm_read(512, 1'b1, -1);
        for (int i = 0; i < 512; i++) model_mem[i] = card_bytes[i];
        readback(0, 511);

        // Random mix of transactions.
        for (int it = 0; it < 4; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) host_write($urandom_range(0, 511), 8'($urandom));
                expect_write_bytes();
                issue(1'b0, 1'b1, $urandom, 1'b1);
                bfm_write();
            end else begin
                random_card();
                issue(1'b1, 1'b0, $urandom, 1'b1);
                bfm_read(512, 1'b1, -1);
                for (int i = 0; i < 512; i++) model_mem[i] = card_bytes[i];
            end
            readback_random(24);
        end

        repeat (5) tick();
        chk("queues_drained", 66'(rd_q.size() + en_q.size() + out_q.size() + exp_w.size() + got_w.size()), 66'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
